// File: rtl/pipe_pkg.sv
// Shared types and constants for the hxd32 fetch-front-end PC sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } pcu_state_t;

  localparam int          PCU_XLEN     = 32;
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam int unsigned PC_ILEN      = 4;

endpackage

// File: rtl/pipe_pcu_if.sv
// Fetch-side bundle of the PC sequencer: hazard/redirect inputs, imem handshake, IF-stage PC output.
interface pipe_pcu_if
  import pipe_pkg::*;
#(
  parameter int XLEN = PCU_XLEN
);

  logic            stall_i;
  logic            br_valid_i;
  logic [XLEN-1:0] br_target_i;
  logic            trap_valid_i;
  logic [XLEN-1:0] trap_vec_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic            pc_valid_o;
  logic [XLEN-1:0] pc_data_o;
  logic            misalign_o;

  modport master (
    input  stall_i, br_valid_i, br_target_i, trap_valid_i, trap_vec_i, imem_ack_i,
    output imem_req_o, imem_addr_o, pc_valid_o, pc_data_o, misalign_o
  );

  modport slave (
    output stall_i, br_valid_i, br_target_i, trap_valid_i, trap_vec_i, imem_ack_i,
    input  imem_req_o, imem_addr_o, pc_valid_o, pc_data_o, misalign_o
  );

endinterface

// File: rtl/pipe_pcu_redir.sv
// Redirect arbiter: trap beats branch; parks the target in pend_q and marks the in-flight fetch killed.
// Latency: redir_vld/redir_tgt combinational, pend_q/kill_q/misalign registered (1 cycle).
// Backpressure: none; a later redirect before the ack simply overwrites pend_q.
module pipe_pcu_redir #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            fetch_busy,
  input  logic            fetch_done,
  output logic            redir_vld,
  output logic [XLEN-1:0] redir_tgt,
  output logic            kill_q,
  output logic [XLEN-1:0] pend_q,
  output logic            misalign
);

  logic [XLEN-1:0] raw_tgt;

  assign redir_vld = trap_valid | br_valid;
  assign raw_tgt   = trap_valid ? trap_vec : br_target;

`ifdef PIPE_PCU_ALIGN_CHK_EN
  logic misalign_q;

  assign redir_tgt = {raw_tgt[XLEN-1:2], 2'b00};
  assign misalign  = misalign_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= redir_vld && (raw_tgt[1:0] != 2'b00);
  end
`else
  assign redir_tgt = raw_tgt;
  assign misalign  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kill_q <= 1'b0;
      pend_q <= '0;
    end else if (fetch_done) begin
      kill_q <= 1'b0;
    end else if (fetch_busy && redir_vld) begin
      kill_q <= 1'b1;
      pend_q <= redir_tgt;
    end
  end

endmodule

// File: rtl/pipe_pcu.sv
// PC sequencer: single-outstanding imem fetch, redirect arbitration, IF-stage PC delivery. Optional PIPE_PCU_ALIGN_CHK_EN.
// Latency: ack at N -> pc_valid_o at N+1; redirect -> request to target at N+1 (or ack+1 if in flight).
// Backpressure: stall_i parks the FSM in HOLD, holding pc_valid_o/pc_data_o and withholding imem_req_o.
module pipe_pcu
  import pipe_pkg::*;
#(
  parameter int              XLEN      = PCU_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC),
  parameter int unsigned     ILEN      = PC_ILEN
) (
  input logic        clk_i,
  input logic        rst_i,
  pipe_pcu_if.master bus
);

  pcu_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] dat_q, dat_d;
  logic            vld_q, vld_d;

  logic            redir_vld;
  logic [XLEN-1:0] redir_tgt;
  logic            kill_q;
  logic [XLEN-1:0] pend_q;
  logic            misalign;
  logic            fetch_busy;
  logic            fetch_done;

  assign fetch_busy = (state_q == REQ) && !bus.imem_ack_i;
  assign fetch_done = (state_q == REQ) &&  bus.imem_ack_i;

  pipe_pcu_redir #(.XLEN(XLEN)) u_redir (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .br_valid   (bus.br_valid_i),
    .br_target  (bus.br_target_i),
    .trap_valid (bus.trap_valid_i),
    .trap_vec   (bus.trap_vec_i),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .redir_vld  (redir_vld),
    .redir_tgt  (redir_tgt),
    .kill_q     (kill_q),
    .pend_q     (pend_q),
    .misalign   (misalign)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      vld_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dat_d   = dat_q;
    // An undelivered PC survives only while IF is stalled and nothing redirects.
    vld_d   = (bus.stall_i && !redir_vld) ? vld_q : 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = REQ;
        if (redir_vld) pc_d = redir_tgt;
      end
      REQ: begin
        if (bus.imem_ack_i) begin
          if (kill_q || redir_vld) begin
            pc_d  = redir_vld ? redir_tgt : pend_q;
            vld_d = 1'b0;
          end else begin
            pc_d    = pc_q + XLEN'(ILEN);
            vld_d   = 1'b1;
            dat_d   = pc_q;
            state_d = bus.stall_i ? HOLD : REQ;
          end
        end
      end
      HOLD: begin
        if (redir_vld) begin
          pc_d    = redir_tgt;
          state_d = REQ;
        end else if (!bus.stall_i) begin
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.imem_req_o  = (state_q == REQ);
  assign bus.imem_addr_o = (state_q == REQ) ? pc_q : '0;
  assign bus.pc_valid_o  = vld_q;
  assign bus.pc_data_o   = dat_q;
  assign bus.misalign_o  = misalign;

endmodule

// File: tb/tb_pipe_pcu.sv
// Directed bench for pipe_pcu: hand-computed fetch/redirect/stall/reset sequences with immediate assertions.
module tb_pipe_pcu;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_pcu_if #(.XLEN(32)) bus ();

  pipe_pcu u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef PIPE_PCU_ALIGN_CHK_EN
  localparam logic        EXP_MIS   = 1'b1;
  localparam logic [31:0] EXP_ALIGN = 32'h0000_0100;
`else
  localparam logic        EXP_MIS   = 1'b0;
  localparam logic [31:0] EXP_ALIGN = 32'h0000_0102;
`endif

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.br_valid_i = 1'b0;
    bus.br_target_i = '0;
    bus.trap_valid_i = 1'b0;
    bus.trap_vec_i = '0;
    bus.imem_ack_i = 1'b0;

    tick();
    tick();
    chk("rst_req",  {31'd0, bus.imem_req_o}, 32'd0);
    chk("rst_addr", bus.imem_addr_o, 32'd0);
    chk("rst_vld",  {31'd0, bus.pc_valid_o}, 32'd0);
    chk("rst_dat",  bus.pc_data_o, 32'd0);
    chk("rst_mis",  {31'd0, bus.misalign_o}, 32'd0);

    // 1: ack tied high, stream 0x0, 0x4, 0x8
    rst = 1'b0;
    bus.imem_ack_i = 1'b1;
    tick();
    chk("t1_req0",  {31'd0, bus.imem_req_o}, 32'd1);
    chk("t1_addr0", bus.imem_addr_o, 32'h0);
    chk("t1_vld0",  {31'd0, bus.pc_valid_o}, 32'd0);
    tick();
    chk("t1_addr1", bus.imem_addr_o, 32'h4);
    chk("t1_vld1",  {31'd0, bus.pc_valid_o}, 32'd1);
    chk("t1_dat1",  bus.pc_data_o, 32'h0);
    tick();
    chk("t1_addr2", bus.imem_addr_o, 32'h8);
    chk("t1_vld2",  {31'd0, bus.pc_valid_o}, 32'd1);
    chk("t1_dat2",  bus.pc_data_o, 32'h4);
    bus.imem_ack_i = 1'b0;

    // 2: ack withheld three cycles, address stable
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_req",  {31'd0, bus.imem_req_o}, 32'd1);
      chk("t2_addr", bus.imem_addr_o, 32'h8);
      chk("t2_vld",  {31'd0, bus.pc_valid_o}, 32'd0);
    end
    bus.imem_ack_i = 1'b1;
    tick();
    chk("t2_vld_ack", {31'd0, bus.pc_valid_o}, 32'd1);
    chk("t2_dat_ack", bus.pc_data_o, 32'h8);
    chk("t2_addr_nx", bus.imem_addr_o, 32'hC);
    bus.imem_ack_i = 1'b0;

    // 3: branch while fetch in flight kills the response
    bus.br_valid_i  = 1'b1;
    bus.br_target_i = 32'h100;
    tick();
    chk("t3_addr_hold", bus.imem_addr_o, 32'hC);
    bus.br_valid_i = 1'b0;
    bus.imem_ack_i = 1'b1;
    tick();
    chk("t3_drop_vld", {31'd0, bus.pc_valid_o}, 32'd0);
    chk("t3_addr_tgt", bus.imem_addr_o, 32'h100);
    tick();
    chk("t3_vld", {31'd0, bus.pc_valid_o}, 32'd1);
    chk("t3_dat", bus.pc_data_o, 32'h100);
    bus.imem_ack_i = 1'b0;

    // 4: trap beats same-cycle branch
    bus.trap_valid_i = 1'b1;
    bus.trap_vec_i   = 32'h80;
    bus.br_valid_i   = 1'b1;
    bus.br_target_i  = 32'h200;
    tick();
    chk("t4_addr_hold", bus.imem_addr_o, 32'h104);
    bus.trap_valid_i = 1'b0;
    bus.br_valid_i   = 1'b0;
    bus.imem_ack_i   = 1'b1;
    tick();
    chk("t4_addr_trap", bus.imem_addr_o, 32'h80);
    chk("t4_drop_vld",  {31'd0, bus.pc_valid_o}, 32'd0);
    tick();
    chk("t4_dat", bus.pc_data_o, 32'h80);
    bus.stall_i = 1'b1;

    // 5: stall after delivery holds outputs, no request
    tick();
    chk("t5_req_hold", {31'd0, bus.imem_req_o}, 32'd0);
    chk("t5_vld_hold", {31'd0, bus.pc_valid_o}, 32'd1);
    chk("t5_dat_hold", bus.pc_data_o, 32'h84);
    bus.imem_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_req_stall", {31'd0, bus.imem_req_o}, 32'd0);
      chk("t5_vld_stall", {31'd0, bus.pc_valid_o}, 32'd1);
      chk("t5_dat_stall", bus.pc_data_o, 32'h84);
    end
    bus.stall_i = 1'b0;
    tick();
    chk("t5_req_rel",  {31'd0, bus.imem_req_o}, 32'd1);
    chk("t5_addr_rel", bus.imem_addr_o, 32'h88);
    chk("t5_vld_rel",  {31'd0, bus.pc_valid_o}, 32'd0);

    // 6: reset mid-fetch wins over a same-cycle ack
    rst = 1'b1;
    bus.imem_ack_i = 1'b1;
    tick();
    chk("t6_req",  {31'd0, bus.imem_req_o}, 32'd0);
    chk("t6_addr", bus.imem_addr_o, 32'd0);
    chk("t6_vld",  {31'd0, bus.pc_valid_o}, 32'd0);
    chk("t6_dat",  bus.pc_data_o, 32'd0);
    rst = 1'b0;
    bus.imem_ack_i = 1'b0;
    tick();
    chk("t6_req_boot",  {31'd0, bus.imem_req_o}, 32'd1);
    chk("t6_addr_boot", bus.imem_addr_o, 32'h0);

    // redirect coincident with ack, then PC wraps past 2^32
    bus.br_valid_i  = 1'b1;
    bus.br_target_i = 32'hFFFF_FFFC;
    bus.imem_ack_i  = 1'b1;
    tick();
    chk("wrap_addr_tgt", bus.imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap_drop_vld", {31'd0, bus.pc_valid_o}, 32'd0);
    bus.br_valid_i = 1'b0;
    tick();
    chk("wrap_dat",  bus.pc_data_o, 32'hFFFF_FFFC);
    chk("wrap_addr", bus.imem_addr_o, 32'h0);
    bus.imem_ack_i = 1'b0;

    // 7: misaligned branch target
    bus.br_valid_i  = 1'b1;
    bus.br_target_i = 32'h102;
    tick();
    chk("t7_mis_set", {31'd0, bus.misalign_o}, {31'd0, EXP_MIS});
    chk("t7_addr_old", bus.imem_addr_o, 32'h0);
    bus.br_valid_i = 1'b0;
    tick();
    chk("t7_mis_clr", {31'd0, bus.misalign_o}, 32'd0);
    bus.imem_ack_i = 1'b1;
    tick();
    chk("t7_addr_tgt", bus.imem_addr_o, EXP_ALIGN);
    bus.imem_ack_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
